fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares the write port of the graphics core's async FIFO between NUM_REQ requesters, e.g. CPU command port, blitter and DMA.
- Grants are round-robin and packet-atomic: once granted, a requester owns the FIFO write port until its packet ends, so packets never interleave in the FIFO.
- Lives entirely in the FIFO write clock domain and drives the FIFO's write/write_data, honouring its can_write.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_WIDTH, 2, width of the requester index; must satisfy 2**IDX_WIDTH >= NUM_REQ.
- DATA_WIDTH, 16, FIFO word width; must be > IDX_WIDTH.
- MAX_BURST, 64, maximum words per grant before forced release (>= 2).
- CNT_WIDTH, 7, burst counter width; must satisfy 2**CNT_WIDTH > MAX_BURST.

Ports:
- reset  input  1  asynchronous, active-high.
- write_clk  input  1  clock; all state is on its rising edge.
- req_valid  input  NUM_REQ  per-requester word valid.
- req_data  input  NUM_REQ*DATA_WIDTH  requester i drives slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  marks the final word of a packet.
- req_ack  output  NUM_REQ  word accepted this cycle (combinational).
- fifo_write  output  1  to FIFO write.
- fifo_write_data  output  DATA_WIDTH  to FIFO write_data.
- fifo_can_write  input  1  from FIFO can_write.
- grant  output  NUM_REQ  one-hot current owner, registered; 0 when idle.
- busy  output  1  state != IDLE.
- burst_overrun  output  1  sticky; set on a forced release.

Behaviour:
- Reset (asynchronous, also mid-packet):
  - state=IDLE, grant=0, cnt=0, burst_overrun=0.
  - Round-robin pointer set so requester 0 has top priority on the first arbitration.
  - fifo_write=0, req_ack=0, busy=0. Any partially written packet stays in the FIFO as-is.
- States: IDLE, HEADER (only with the optional feature), BURST.
- IDLE:
  - fifo_write=0.
  - If any req_valid is set, select the first set bit scanning from (last_owner+1) mod NUM_REQ upward with wrap.
  - Register the one-hot grant, clear cnt, and go to BURST (HEADER if the feature is enabled).
  - Arbitration costs exactly 1 idle cycle per packet.
- BURST, with g = granted index:
  - fifo_write = req_valid[g].
  - fifo_write_data = req_data slice g.
  - A word is accepted when fifo_write && fifo_can_write.
  - req_ack[g] = accepted; all other req_ack bits are 0.
- On accept in BURST:
  - If req_last[g]=1: go to IDLE, last_owner=g, grant=0.
  - Else if cnt == MAX_BURST-1: this is the MAX_BURST-th word. Go to IDLE, last_owner=g, set burst_overrun. The rest of the packet re-arbitrates as a new packet.
  - Else cnt=cnt+1.
- Stall cases in BURST:
  - req_valid[g]=0: grant is held, no write, no timeout.
  - fifo_can_write=0 with valid=1: fifo_write stays 1; the word is not accepted and the requester must hold data/last stable until req_ack.
- Requests from non-granted requesters are ignored until the return to IDLE. Simultaneous requests are resolved only by the round-robin order.
- A requester must not drop req_valid after asserting it for a word until acked; if it does, nothing is written for it.
- last_owner is updated only on packet end or forced release.

Optional Feature:
- Macro: FIFO_ARB_HEADER_EN.
- Defined:
  - IDLE goes to HEADER, which drives fifo_write=1.
  - Header data: bit DATA_WIDTH-1 = 1, bits [IDX_WIDTH-1:0] = g, all other bits 0.
  - On accept (fifo_can_write=1) go to BURST; no req_ack in HEADER.
  - Header words do not count toward MAX_BURST.
  - A forced release emits a fresh header when re-granted.
- Undefined: the HEADER state and its logic are absent; IDLE goes directly to BURST and packets are written unframed.

Test Plan:
- Reset, then requester 1 sends 3 words 0x0011, 0x0022, 0x0033 (last on the third), fifo_can_write=1 -> grant=0b0010 one cycle after valid; FIFO receives the 3 words on consecutive cycles; grant=0 and busy=0 after the third.
- req_valid=0b1111, all packets 1 word, fifo_can_write=1 -> grant order 0,1,2,3,0 with one idle cycle between grants.
- Requester 2 in a 4-word packet; requester 0 raises valid after word 1 -> FIFO holds all 4 words of requester 2 contiguously before any word of requester 0.
- During requester 3's burst, hold fifo_can_write=0 for 5 cycles -> fifo_write stays 1, req_ack=0, data stable, no word lost; the burst resumes when can_write returns to 1.
- MAX_BURST=4, 6-word packet with no competitors -> 4 words, release, burst_overrun=1, re-grant after 1 idle cycle, remaining 2 words written. With FIFO_ARB_HEADER_EN: 0x8000|idx header before each segment.
- Assert reset mid-burst after 2 of 5 words -> grant=0, fifo_write=0 immediately; after reset release, requester 0 wins first when all request.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares one async-FIFO write port between NUM_REQ requesters.
// Round-robin, packet-atomic grants; a grant is held until the packet's last word
// or until MAX_BURST words have gone through, which forces a release and sets the
// sticky burst_overrun flag.
// Optional feature macro FIFO_ARB_HEADER_EN: when defined, each grant first writes
// a header word {1'b1, zeros, owner index} before the owner's data words.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 64,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                          reset,
  input  logic                          write_clk,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  input  logic                          fifo_can_write,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          burst_overrun
);

`ifdef FIFO_ARB_HEADER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HEADER = 2'd1, BURST = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd2} state_t;
`endif

  state_t               state, state_next;
  logic [NUM_REQ-1:0]   grant_next;
  logic [IDX_WIDTH-1:0] owner_idx, owner_idx_next;
  logic [IDX_WIDTH-1:0] last_owner, last_owner_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 overrun_next;

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  arb_found;
  logic [IDX_WIDTH-1:0]  arb_idx;
  logic                  accept;

`ifdef FIFO_ARB_HEADER_EN
  logic [DATA_WIDTH-1:0] header_word;

  // Header word: top bit marks a header, low bits carry the owner index
  always_comb begin
    header_word                  = '0;
    header_word[DATA_WIDTH-1]    = 1'b1;
    header_word[IDX_WIDTH-1:0]   = owner_idx;
  end
`endif

  // State and grant registers; reset leaves requester 0 first in round-robin order
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= '0;
      owner_idx     <= '0;
      last_owner    <= IDX_WIDTH'(NUM_REQ - 1);
      cnt           <= '0;
      burst_overrun <= 1'b0;
    end else begin
      state         <= state_next;
      grant         <= grant_next;
      owner_idx     <= owner_idx_next;
      last_owner    <= last_owner_next;
      cnt           <= cnt_next;
      burst_overrun <= overrun_next;
    end
  end

  // Pick out the current owner's valid/last/data lanes
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (owner_idx == IDX_WIDTH'(j)) begin
        sel_valid = req_valid[j];
        sel_last  = req_last[j];
        sel_data  = req_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin search: first valid requester starting just after the last owner
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!arb_found && req_valid[j] &&
            (j == (int'(last_owner) + 1 + i) % NUM_REQ)) begin
          arb_found = 1'b1;
          arb_idx   = IDX_WIDTH'(j);
        end
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, hold the grant until last word or burst limit
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    owner_idx_next  = owner_idx;
    last_owner_next = last_owner;
    cnt_next        = cnt;
    overrun_next    = burst_overrun;
    case (state)
      IDLE: begin
        if (arb_found) begin
          grant_next     = NUM_REQ'(1) << arb_idx;
          owner_idx_next = arb_idx;
          cnt_next       = '0;
`ifdef FIFO_ARB_HEADER_EN
          state_next     = HEADER;
`else
          state_next     = BURST;
`endif
        end
      end
`ifdef FIFO_ARB_HEADER_EN
      HEADER: begin
        if (fifo_can_write) begin
          state_next = BURST;
        end
      end
`endif
      BURST: begin
        if (accept) begin
          if (sel_last) begin
            state_next      = IDLE;
            grant_next      = '0;
            last_owner_next = owner_idx;
          end else if (cnt == CNT_WIDTH'(MAX_BURST - 1)) begin
            state_next      = IDLE;
            grant_next      = '0;
            last_owner_next = owner_idx;
            overrun_next    = 1'b1;
          end else begin
            cnt_next = cnt + CNT_WIDTH'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // FIFO write port and per-requester acknowledges
  always_comb begin
    fifo_write      = 1'b0;
    fifo_write_data = '0;
    req_ack         = '0;
    case (state)
`ifdef FIFO_ARB_HEADER_EN
      HEADER: begin
        fifo_write      = 1'b1;
        fifo_write_data = header_word;
      end
`endif
      BURST: begin
        fifo_write      = sel_valid;
        fifo_write_data = sel_data;
        if (sel_valid && fifo_can_write) begin
          req_ack = NUM_REQ'(1) << owner_idx;
        end
      end
      default: begin
        fifo_write = 1'b0;
      end
    endcase
  end

  assign accept = fifo_write && fifo_can_write;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed scenarios plus randomized packet traffic for
// fifo_write_arbiter. Requester drivers feed queued words, a packet-level
// round-robin model predicts the FIFO write stream, and a monitor scoreboards it.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int IDX_WIDTH  = 2;
  localparam int DATA_WIDTH = 16;
  localparam int MAX_BURST  = 4;
  localparam int CNT_WIDTH  = 7;
`ifdef FIFO_ARB_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } word_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [NUM_REQ-1:0]    src;
    logic                  is_header;
  } exp_t;

  logic                          reset;
  logic                          write_clk;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ack;
  logic                          fifo_write;
  logic [DATA_WIDTH-1:0]         fifo_write_data;
  logic                          fifo_can_write;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          burst_overrun;

  word_t drv_q[NUM_REQ][$];
  word_t mdl_q[NUM_REQ][$];
  exp_t  exp_q[$];
  int    acc_log[$];
  int    acked_cnt[NUM_REQ];
  int    model_last;
  bit    exp_overrun;
  bit    cw_random;
  bit    cw_force;
  int    cycle_cnt;
  int    checks;
  int    failures;

  fifo_write_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST (MAX_BURST),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .reset          (reset),
    .write_clk      (write_clk),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ack        (req_ack),
    .fifo_write     (fifo_write),
    .fifo_write_data(fifo_write_data),
    .fifo_can_write (fifo_can_write),
    .grant          (grant),
    .busy           (busy),
    .burst_overrun  (burst_overrun)
  );

  // Free-running write clock
  initial begin
    write_clk = 1'b0;
    forever #5 write_clk = ~write_clk;
  end

  // Cycle counter used to time-stamp accepted data words
  initial cycle_cnt = 0;
  always @(posedge write_clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d",
               name, actual, expected, cycle_cnt);
    end
  endtask

  // Queue one packet of len words for requester r, both for the driver and the model
  task automatic applyStimulus(input int r, input int len,
                               input logic [DATA_WIDTH-1:0] first,
                               input logic [DATA_WIDTH-1:0] step);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.data = first + DATA_WIDTH'(i) * step;
      w.last = (i == len - 1);
      drv_q[r].push_back(w);
      mdl_q[r].push_back(w);
    end
  endtask

  // Packet-level round-robin model: drain every pending model packet into exp_q
  task automatic modelRun();
    int r;
    int n;
    bit found;
    bit seg_done;
    word_t w;
    exp_t e;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      r = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
        if (!found && mdl_q[(model_last + i) % NUM_REQ].size() > 0) begin
          found = 1'b1;
          r = (model_last + i) % NUM_REQ;
        end
      end
      if (found) begin
        if (HDR != 0) begin
          e.data = DATA_WIDTH'(r);
          e.data[DATA_WIDTH-1] = 1'b1;
          e.src = NUM_REQ'(1) << r;
          e.is_header = 1'b1;
          exp_q.push_back(e);
        end
        n = 0;
        seg_done = 1'b0;
        while (!seg_done) begin
          w = mdl_q[r].pop_front();
          e.data = w.data;
          e.src = NUM_REQ'(1) << r;
          e.is_header = 1'b0;
          exp_q.push_back(e);
          n++;
          if (w.last) seg_done = 1'b1;
          else if (n == MAX_BURST) begin
            exp_overrun = 1'b1;
            seg_done = 1'b1;
          end
        end
        model_last = r;
      end
    end
  endtask

  function automatic int pendingWords();
    int s;
    s = 0;
    for (int r = 0; r < NUM_REQ; r++) s += drv_q[r].size();
    return s;
  endfunction

  // Assert reset, check the immediate effect, flush all queues, then release
  task automatic assertReset(input string name);
    @(posedge write_clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput({name, "_grant"}, 32'(grant), 32'd0);
    checkOutput({name, "_fifo_write"}, 32'(fifo_write), 32'd0);
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_req_ack"}, 32'(req_ack), 32'd0);
    checkOutput({name, "_overrun"}, 32'(burst_overrun), 32'd0);
    exp_q.delete();
    for (int r = 0; r < NUM_REQ; r++) begin
      drv_q[r].delete();
      mdl_q[r].delete();
    end
    model_last = NUM_REQ - 1;
    exp_overrun = 1'b0;
    repeat (2) @(posedge write_clk);
    #1;
    reset = 1'b0;
  endtask

  // Wait (bounded) until every queued word has been written and the arbiter is idle
  task automatic waitDrain(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || pendingWords() != 0 || busy) && c < 2000) begin
      @(posedge write_clk);
      #1;
      c++;
    end
    checkOutput({name, "_drained"}, 32'(c < 2000), 32'd1);
    checkOutput({name, "_overrun"}, 32'(burst_overrun), 32'(exp_overrun));
    checkOutput({name, "_idle_grant"}, 32'(grant), 32'd0);
  endtask

  task automatic waitAcks(input string name, input int r, input int count);
    int base;
    int c;
    base = acked_cnt[r];
    c = 0;
    while (acked_cnt[r] < base + count && c < 200) begin
      @(posedge write_clk);
      #1;
      c++;
    end
    checkOutput({name, "_acks_seen"}, 32'(c < 200), 32'd1);
  endtask

  // Requester drivers: present queue heads on the falling edge, retire words on ack
  initial begin
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    fifo_can_write = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) acked_cnt[r] = 0;
    forever begin
      @(negedge write_clk);
      for (int r = 0; r < NUM_REQ; r++) begin
        if (drv_q[r].size() > 0) begin
          req_valid[r] = 1'b1;
          req_data[r*DATA_WIDTH +: DATA_WIDTH] = drv_q[r][0].data;
          req_last[r] = drv_q[r][0].last;
        end else begin
          req_valid[r] = 1'b0;
          req_data[r*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
          req_last[r] = 1'($urandom_range(0, 1));
        end
      end
      fifo_can_write = cw_random ? ($urandom_range(0, 9) < 7) : cw_force;
      #4;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (req_ack[r] && drv_q[r].size() > 0) begin
          word_t w;
          w = drv_q[r].pop_front();
          acked_cnt[r]++;
        end
      end
    end
  end

  // Monitor: compare every accepted FIFO write against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge write_clk);
      #4;
      if (!reset) begin
        if (fifo_write && fifo_can_write) begin
          checkOutput("write_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("write_data", 32'(fifo_write_data), 32'(e.data));
            checkOutput("write_grant", 32'(grant), 32'(e.src));
            checkOutput("write_ack", 32'(req_ack),
                        32'(e.is_header ? {NUM_REQ{1'b0}} : e.src));
            if (!e.is_header) acc_log.push_back(cycle_cnt);
          end
        end else begin
          checkOutput("no_write_ack", 32'(req_ack), 32'd0);
        end
      end
    end
  end

  // Global time limit
  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] time limit reached");
  end

  // Main sequence of directed scenarios followed by random rounds
  initial begin
    int exp_g[$];
    int owners[5];
    checks = 0;
    failures = 0;
    cw_random = 1'b0;
    cw_force = 1'b1;
    model_last = NUM_REQ - 1;
    exp_overrun = 1'b0;
    reset = 1'b0;
    owners = '{0, 1, 2, 3, 0};

    assertReset("rst0");

    $display("[TB] single packet from requester 1");
    @(posedge write_clk);
    #1;
    acc_log.delete();
    applyStimulus(1, 3, 16'h0011, 16'h0011);
    modelRun();
    for (int s = 0; s < 6; s++) begin
      @(negedge write_clk);
      #2;
      if (s == 0) checkOutput("t1_pre_grant", 32'(grant), 32'd0);
      if (s == 1) checkOutput("t1_grant", 32'(grant), 32'b0010);
      if (s == 3 + HDR) checkOutput("t1_busy_last", 32'(busy), 32'd1);
      if (s == 4 + HDR) begin
        checkOutput("t1_busy_after", 32'(busy), 32'd0);
        checkOutput("t1_grant_after", 32'(grant), 32'd0);
      end
    end
    waitDrain("t1");
    checkOutput("t1_words", 32'(acc_log.size()), 32'd3);
    if (acc_log.size() == 3)
      checkOutput("t1_consecutive", 32'(acc_log[2] - acc_log[0]), 32'd2);

    $display("[TB] all requesters, one-word packets");
    assertReset("rst1");
    @(posedge write_clk);
    #1;
    applyStimulus(0, 1, 16'h0A00, 16'h0001);
    applyStimulus(0, 1, 16'h0A01, 16'h0001);
    applyStimulus(1, 1, 16'h0B00, 16'h0001);
    applyStimulus(2, 1, 16'h0C00, 16'h0001);
    applyStimulus(3, 1, 16'h0D00, 16'h0001);
    modelRun();
    exp_g.push_back(0);
    foreach (owners[k]) begin
      for (int h = 0; h < 1 + HDR; h++) exp_g.push_back(1 << owners[k]);
      exp_g.push_back(0);
    end
    foreach (exp_g[k]) begin
      @(negedge write_clk);
      #2;
      checkOutput("t2_grant_seq", 32'(grant), 32'(exp_g[k]));
    end
    waitDrain("t2");

    $display("[TB] late competitor during a packet");
    @(posedge write_clk);
    #1;
    applyStimulus(2, 4, 16'h2000, 16'h0001);
    modelRun();
    waitAcks("t3", 2, 1);
    applyStimulus(0, 2, 16'h0C10, 16'h0001);
    modelRun();
    waitDrain("t3");

    $display("[TB] can_write stall during requester 3 burst");
    @(posedge write_clk);
    #1;
    applyStimulus(3, 4, 16'h3000, 16'h0111);
    modelRun();
    waitAcks("t4", 3, 1);
    cw_force = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge write_clk);
      #2;
      checkOutput("t4_stall_write", 32'(fifo_write), 32'd1);
      checkOutput("t4_stall_ack", 32'(req_ack), 32'd0);
      checkOutput("t4_stall_data", 32'(fifo_write_data), 32'h3111);
      checkOutput("t4_stall_grant", 32'(grant), 32'b1000);
    end
    cw_force = 1'b1;
    waitDrain("t4");

    $display("[TB] packet longer than the burst limit");
    @(posedge write_clk);
    #1;
    acc_log.delete();
    applyStimulus(1, 6, 16'h1000, 16'h0001);
    modelRun();
    waitDrain("t5");
    checkOutput("t5_overrun_set", 32'(burst_overrun), 32'd1);
    checkOutput("t5_words", 32'(acc_log.size()), 32'd6);
    if (acc_log.size() == 6) begin
      checkOutput("t5_first_seg", 32'(acc_log[3] - acc_log[0]), 32'd3);
      checkOutput("t5_regrant_gap", 32'(acc_log[4] - acc_log[3]), 32'(2 + HDR));
      checkOutput("t5_second_seg", 32'(acc_log[5] - acc_log[4]), 32'd1);
    end

    $display("[TB] reset in the middle of a burst");
    @(posedge write_clk);
    #1;
    applyStimulus(2, 5, 16'h5000, 16'h0001);
    modelRun();
    waitAcks("t6", 2, 2);
    assertReset("t6_rst");
    @(posedge write_clk);
    #1;
    for (int r = 0; r < NUM_REQ; r++)
      applyStimulus(r, 1, DATA_WIDTH'(16'h6000 + r), 16'h0001);
    modelRun();
    for (int s = 0; s < 2; s++) begin
      @(negedge write_clk);
      #2;
      if (s == 1) checkOutput("t6_first_grant", 32'(grant), 32'b0001);
    end
    waitDrain("t6");

    $display("[TB] randomized traffic");
    for (int round = 0; round < 6; round++) begin
      @(posedge write_clk);
      #1;
      cw_random = 1'b1;
      for (int r = 0; r < NUM_REQ; r++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++)
          applyStimulus(r, $urandom_range(1, 7), DATA_WIDTH'($urandom),
                        DATA_WIDTH'($urandom_range(1, 255)));
      end
      modelRun();
      waitDrain("rand");
      cw_random = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
